// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: absolute value on entry, sign restore on exit.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  // Negate when requested; the most negative value maps onto itself, which
  // reads correctly as an unsigned magnitude.
  always_comb begin
    out_val = neg ? (~in_val + W'(1)) : in_val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            hi_wr,
  input  logic            lo_wr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_nxt;
  logic              done_q, done_d;

  md_op_e            op_in;
  logic              op_in_signed, sgn_a, sgn_b, is_div_q, last_iter;
  logic [XLEN-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;

  assign op_in        = md_op_e'(op);
  assign op_in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign sgn_a        = op_in_signed & in_a[XLEN-1];
  assign sgn_b        = op_in_signed & in_b[XLEN-1];
  assign is_div_q     = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign last_iter    = (state_q == CALC) && (cnt_q == CW'(XLEN - 1));

  muldiv_signfix #(.W(XLEN)) u_abs_a (.in_val(in_a), .neg(sgn_a), .out_val(abs_a));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.in_val(in_b), .neg(sgn_b), .out_val(abs_b));

  muldiv_signfix #(.W(2*XLEN)) u_fix_prod (
    .in_val(acc_nxt), .neg(neg_a_q ^ neg_b_q), .out_val(prod_fix)
  );
  muldiv_signfix #(.W(XLEN)) u_fix_quo (
    .in_val(acc_nxt[XLEN-1:0]), .neg(neg_a_q ^ neg_b_q), .out_val(quo_fix)
  );
  muldiv_signfix #(.W(XLEN)) u_fix_rem (
    .in_val(acc_nxt[2*XLEN-1:XLEN]), .neg(neg_a_q), .out_val(rem_fix)
  );

  // One iteration: shift-add for multiply, restoring step for divide.
  // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, mag_b_q};
    if (is_div_q) begin
      if (!rem_diff[XLEN]) acc_nxt = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_nxt = {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      a_raw_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      a_raw_q <= a_raw_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, iteration, result write-back, MTHI/MTLO.
  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    a_raw_d = a_raw_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        op_d    = op_in;
        neg_a_d = sgn_a;
        neg_b_d = sgn_b;
        mag_a_d = abs_a;
        mag_b_d = abs_b;
        a_raw_d = in_a;
        cnt_d   = '0;
        acc_d   = op_in[1] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
      end else begin
        if (hi_wr) hi_d = wdata;
        if (lo_wr) lo_d = wdata;
      end
    end else begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        cnt_d  = '0;
        done_d = 1'b1;
        if (is_div_q) begin
          // Zero divisor bypasses the sign fix and returns the raw dividend.
          if (mag_b_q == '0) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
    end
  end

  // Output decode.
  always_comb begin
    busy = (state_q == CALC);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule
